// File: rtl/boot_load_sequencer.sv
// Boot loader sequencer: steers programmer words into ICCM/DCCM while the core
// is held in reset, releases the core a fixed delay after programming ends,
// then hands the memory port over to the core.
// Ports: clk_i/rst_ni; prog_* programmer write port; core_* core memory port
// (core_gnt_o = grant); mem_* registered memory port; core_rst_no core reset;
// iccm_words_o/dccm_words_o saturating word counters; err_o sticky error.
module boot_load_sequencer #(
  parameter int unsigned          ADDR_W         = 14,
  parameter int unsigned          DATA_W         = 64,
  parameter logic [DATA_W-1:0]    SECTION_MARK   = 64'h0000_0000_0000_0FFE,
  parameter int unsigned          RELEASE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_wdata_i,
  input  logic              prog_done_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic              core_sel_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              core_rst_no,
  output logic [ADDR_W:0]   iccm_words_o,
  output logic [ADDR_W:0]   dccm_words_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  typedef enum logic [2:0] {
    BOOT_WAIT = 3'd0,
    LOAD_ICCM = 3'd1,
    LOAD_DCCM = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    rel_cnt_q, rel_cnt_d;

  logic                mem_req_d, mem_we_d, mem_sel_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                core_rst_n_d;
  logic [ADDR_W:0]     iccm_words_d, dccm_words_d;
  logic                err_d;
  logic                is_mark;

  assign is_mark = (prog_wdata_i == SECTION_MARK);

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT_WAIT;
      base_q       <= '0;
      rel_cnt_q    <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_sel_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      core_rst_no  <= 1'b0;
      iccm_words_o <= '0;
      dccm_words_o <= '0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      rel_cnt_q    <= rel_cnt_d;
      mem_req_o    <= mem_req_d;
      mem_we_o     <= mem_we_d;
      mem_sel_o    <= mem_sel_d;
      mem_addr_o   <= mem_addr_d;
      mem_wdata_o  <= mem_wdata_d;
      core_rst_no  <= core_rst_n_d;
      iccm_words_o <= iccm_words_d;
      dccm_words_o <= dccm_words_d;
      err_o        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    rel_cnt_d    = rel_cnt_q;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_sel_d    = mem_sel_o;
    mem_addr_d   = mem_addr_o;
    mem_wdata_d  = mem_wdata_o;
    core_rst_n_d = core_rst_no;
    iccm_words_d = iccm_words_o;
    dccm_words_d = dccm_words_o;
    err_d        = err_o;
    core_gnt_o   = 1'b0;

    unique case (state_q)
      BOOT_WAIT, LOAD_ICCM: begin
        if (prog_we_i) begin
          if (is_mark) begin
            // DCCM image is addressed from the word after the marker
            base_d  = prog_addr_i + ADDR_W'(1);
            state_d = LOAD_DCCM;
          end else begin
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b1;
            mem_sel_d    = 1'b0;
            mem_addr_d   = prog_addr_i;
            mem_wdata_d  = prog_wdata_i;
            iccm_words_d = sat_inc(iccm_words_o);
            state_d      = LOAD_ICCM;
          end
        end
        // From BOOT_WAIT a concurrent word takes priority; done is seen next cycle
        if (prog_done_i && !(state_q == BOOT_WAIT && prog_we_i)) begin
          state_d   = RELEASE;
          rel_cnt_d = CNT_W'(RELEASE_CYCLES - 1);
        end
      end

      LOAD_DCCM: begin
        if (prog_we_i) begin
          if (is_mark) begin
            err_d = 1'b1;
          end else begin
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b1;
            mem_sel_d    = 1'b1;
            mem_addr_d   = prog_addr_i - base_q;
            mem_wdata_d  = prog_wdata_i;
            dccm_words_d = sat_inc(dccm_words_o);
          end
        end
        if (prog_done_i) begin
          state_d   = RELEASE;
          rel_cnt_d = CNT_W'(RELEASE_CYCLES - 1);
        end
      end

      RELEASE: begin
        if (prog_we_i) err_d = 1'b1;
        if (rel_cnt_q == '0) begin
          core_rst_n_d = 1'b1;
          state_d      = RUN;
        end else begin
          rel_cnt_d = rel_cnt_q - 1'b1;
        end
      end

      RUN: begin
        if (prog_we_i) err_d = 1'b1;
        core_gnt_o = core_req_i;
        if (core_req_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = core_we_i;
          mem_sel_d   = core_sel_i;
          mem_addr_d  = core_addr_i;
          mem_wdata_d = core_wdata_i;
        end
      end

      default: begin
        state_d = BOOT_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Directed testbench for boot_load_sequencer.
// Ports: none; drives the DUT with default parameters from one initial block.
// Prints a single summary line at the end.
module tb_boot_load_sequencer;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;
  localparam logic [63:0] MARK = 64'h0000_0000_0000_0FFE;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              prog_we_i;
  logic [ADDR_W-1:0] prog_addr_i;
  logic [DATA_W-1:0] prog_wdata_i;
  logic              prog_done_i;
  logic              core_req_i;
  logic              core_we_i;
  logic              core_sel_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic              core_gnt_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic              mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              core_rst_no;
  logic [ADDR_W:0]   iccm_words_o;
  logic [ADDR_W:0]   dccm_words_o;
  logic              err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  boot_load_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_wdata_i (prog_wdata_i),
    .prog_done_i  (prog_done_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_sel_i   (core_sel_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_gnt_o   (core_gnt_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_sel_o    (mem_sel_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rst_no  (core_rst_no),
    .iccm_words_o (iccm_words_o),
    .dccm_words_o (dccm_words_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"}, 64'(mem_req_o), 64'd0);
    chk({tag, ".mem_we"}, 64'(mem_we_o), 64'd0);
    chk({tag, ".mem_sel"}, 64'(mem_sel_o), 64'd0);
    chk({tag, ".mem_addr"}, 64'(mem_addr_o), 64'd0);
    chk({tag, ".mem_wdata"}, mem_wdata_o, 64'd0);
    chk({tag, ".core_rst_n"}, 64'(core_rst_no), 64'd0);
    chk({tag, ".iccm_words"}, 64'(iccm_words_o), 64'd0);
    chk({tag, ".dccm_words"}, 64'(dccm_words_o), 64'd0);
    chk({tag, ".err"}, 64'(err_o), 64'd0);
    chk({tag, ".core_gnt"}, 64'(core_gnt_o), 64'd0);
  endtask

  // Reset held over two edges, released 1ns after a rising edge.
  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    prog_we_i = 1'b0; prog_addr_i = '0; prog_wdata_i = '0; prog_done_i = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0; core_sel_i = 1'b0;
    core_addr_i = '0; core_wdata_i = '0;
    #2;
    chk_all_zero(tag);
    step();
    step();
    rst_ni = 1'b1;
  endtask

  // Present one programmer word for one edge; outputs are checked by the caller.
  task automatic prog_word(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    prog_we_i = 1'b1; prog_addr_i = a; prog_wdata_i = d;
    step();
    prog_we_i = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic sel, input logic [ADDR_W-1:0] a,
                           input logic [63:0] d);
    chk({tag, ".req"}, 64'(mem_req_o), 64'd1);
    chk({tag, ".we"}, 64'(mem_we_o), 64'd1);
    chk({tag, ".sel"}, 64'(mem_sel_o), 64'(sel));
    chk({tag, ".addr"}, 64'(mem_addr_o), 64'(a));
    chk({tag, ".wdata"}, mem_wdata_o, d);
  endtask

  // Called after the edge that entered RELEASE: three more edges keep the
  // core in reset, the fourth releases it.
  task automatic release_wait(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, ".rst_held"}, 64'(core_rst_no), 64'd0);
      chk({tag, ".no_mem"}, 64'(mem_req_o), 64'd0);
      chk({tag, ".gnt_off"}, 64'(core_gnt_o), 64'd0);
    end
    step();
    chk({tag, ".rst_rel"}, 64'(core_rst_no), 64'd1);
  endtask

  initial begin
    // ---------------- test 1: three ICCM words then done -------------
    do_reset("rst1");
    core_req_i = 1'b1;  // must not be granted before RUN
    #1;
    chk("t1.gnt_boot", 64'(core_gnt_o), 64'd0);
    core_req_i = 1'b0;
    prog_word(14'd0, 64'hA0A0_A0A0_0000_0000);
    chk_write("t1.w0", 1'b0, 14'd0, 64'hA0A0_A0A0_0000_0000);
    prog_word(14'd1, 64'hA1A1_A1A1_0000_0001);
    chk_write("t1.w1", 1'b0, 14'd1, 64'hA1A1_A1A1_0000_0001);
    prog_word(14'd2, 64'hA2A2_A2A2_0000_0002);
    chk_write("t1.w2", 1'b0, 14'd2, 64'hA2A2_A2A2_0000_0002);
    chk("t1.iccm_words", 64'(iccm_words_o), 64'd3);
    prog_done_i = 1'b1;
    core_req_i  = 1'b1;
    step();  // enters RELEASE
    chk("t1.rel_entry_rst", 64'(core_rst_no), 64'd0);
    chk("t1.rel_entry_req", 64'(mem_req_o), 64'd0);
    release_wait("t1");
    chk("t1.dccm_words", 64'(dccm_words_o), 64'd0);
    chk("t1.err", 64'(err_o), 64'd0);

    // ---------------- test 4: core access in RUN + stray prog write ---
    core_req_i = 1'b1; core_we_i = 1'b1; core_sel_i = 1'b1;
    core_addr_i = 14'h10; core_wdata_i = 64'hC0DE_C0DE_1234_5678;
    prog_we_i = 1'b1; prog_addr_i = 14'd7; prog_wdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("t4.gnt", 64'(core_gnt_o), 64'd1);
    step();
    prog_we_i = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0;
    chk_write("t4.mirror", 1'b1, 14'h10, 64'hC0DE_C0DE_1234_5678);
    chk("t4.err", 64'(err_o), 64'd1);
    chk("t4.iccm_unchanged", 64'(iccm_words_o), 64'd3);
    #1;
    chk("t4.gnt_idle", 64'(core_gnt_o), 64'd0);
    step();
    chk("t4.idle_req", 64'(mem_req_o), 64'd0);
    chk("t4.err_sticky", 64'(err_o), 64'd1);
    chk("t4.still_run", 64'(core_rst_no), 64'd1);

    // ---------------- test 2: ICCM, marker, DCCM rebased --------------
    do_reset("rst2");
    prog_word(14'd0, 64'h1111_0000_0000_0000);
    chk_write("t2.i0", 1'b0, 14'd0, 64'h1111_0000_0000_0000);
    prog_word(14'd1, 64'h1111_0000_0000_0001);
    chk_write("t2.i1", 1'b0, 14'd1, 64'h1111_0000_0000_0001);
    prog_word(14'd2, MARK);
    chk("t2.mark_no_write", 64'(mem_req_o), 64'd0);
    prog_word(14'd3, 64'h2222_0000_0000_0000);
    chk_write("t2.d0", 1'b1, 14'd0, 64'h2222_0000_0000_0000);
    prog_word(14'd4, 64'h2222_0000_0000_0001);
    chk_write("t2.d1", 1'b1, 14'd1, 64'h2222_0000_0000_0001);
    chk("t2.iccm_words", 64'(iccm_words_o), 64'd2);
    chk("t2.dccm_words", 64'(dccm_words_o), 64'd2);
    chk("t2.err_clear", 64'(err_o), 64'd0);
    prog_word(14'd5, MARK);  // second marker is an error
    chk("t2.mark2_no_write", 64'(mem_req_o), 64'd0);
    chk("t2.mark2_err", 64'(err_o), 64'd1);
    chk("t2.dccm_words2", 64'(dccm_words_o), 64'd2);

    // ---------------- test 5: reset mid LOAD_DCCM ---------------------
    prog_word(14'd6, 64'h2222_0000_0000_0003);
    chk_write("t5.d3", 1'b1, 14'd3, 64'h2222_0000_0000_0003);
    #2;
    rst_ni = 1'b0;  // asynchronous, mid-cycle
    #1;
    chk_all_zero("t5.async");
    step();
    rst_ni = 1'b1;
    prog_word(14'd0, 64'h3333_0000_0000_0000);
    chk_write("t5.reload", 1'b0, 14'd0, 64'h3333_0000_0000_0000);
    chk("t5.iccm_words", 64'(iccm_words_o), 64'd1);
    chk("t5.dccm_words", 64'(dccm_words_o), 64'd0);

    // ---------------- test 3: word and done in the same cycle ---------
    prog_done_i = 1'b1;
    prog_word(14'd1, 64'h3333_0000_0000_0001);
    chk_write("t3.last_word", 1'b0, 14'd1, 64'h3333_0000_0000_0001);
    chk("t3.iccm_words", 64'(iccm_words_o), 64'd2);
    chk("t3.rst_held", 64'(core_rst_no), 64'd0);
    release_wait("t3");
    chk("t3.err", 64'(err_o), 64'd0);

    // ---------------- test 6: done straight after reset ---------------
    do_reset("rst6");
    prog_done_i = 1'b1;
    step();  // BOOT_WAIT -> RELEASE
    chk("t6.entry_req", 64'(mem_req_o), 64'd0);
    chk("t6.entry_rst", 64'(core_rst_no), 64'd0);
    prog_we_i = 1'b1; prog_addr_i = 14'd9; prog_wdata_i = 64'h4444;
    release_wait("t6");
    prog_we_i = 1'b0;
    chk("t6.iccm_words", 64'(iccm_words_o), 64'd0);
    chk("t6.dccm_words", 64'(dccm_words_o), 64'd0);
    chk("t6.err_release_write", 64'(err_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
